// File: rtl/mti_pulse_integrator.sv
// mti_pulse_integrator
// MTI canceller (bypass / 2-pulse / 3-pulse) followed by coherent integration of
// NUM_PULSES pulses per range bin. One integrated range line is emitted per frame.
// Optional build macro: MTI_ABS2_EN adds acc_abs2 (acc_I^2 + acc_Q^2) and one extra
// output register stage on all acc_* outputs.
// Pipeline: sample edge -> s1 (input + delay-line read) -> s2 (canceller result)
//           -> MTI outputs / s3 (accumulator read) -> acc outputs.

module mti_pulse_integrator #(
    parameter  int WIDTH      = 12,
    parameter  int RANGE_BINS = 512,
    parameter  int NUM_PULSES = 16,
    localparam int MTI_W      = WIDTH + 2,
    localparam int ACC_W      = MTI_W + $clog2(NUM_PULSES),
    localparam int BIN_W      = $clog2(RANGE_BINS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rec_flag,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   signal_I,
    input  logic [WIDTH-1:0]   signal_Q,
    output logic [MTI_W-1:0]   MTI_I_out,
    output logic [MTI_W-1:0]   MTI_Q_out,
    output logic               mti_valid,
    output logic [ACC_W-1:0]   acc_I,
    output logic [ACC_W-1:0]   acc_Q,
    output logic               acc_valid,
    output logic [BIN_W-1:0]   acc_bin,
    output logic               start_flag,
    output logic               frame_done
`ifdef MTI_ABS2_EN
    ,
    output logic [2*ACC_W-1:0] acc_abs2
`endif
);

    localparam int PULSE_W = $clog2(NUM_PULSES);
    localparam int EXT     = MTI_W - WIDTH;
    localparam int AEXT    = ACC_W - MTI_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_TWO    = 2'd1,
        MODE_THREE  = 2'd2
    } mode_t;

    function automatic logic signed [MTI_W-1:0] sext_in(input logic [WIDTH-1:0] v);
        return {{EXT{v[WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_mti(input logic [MTI_W-1:0] v);
        return {{AEXT{v[MTI_W-1]}}, v};
    endfunction

    // ------------------------------------------------------------------
    // Front end: frame FSM and bin/pulse counters
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [BIN_W-1:0]     bin_q, bin_d;
    logic [PULSE_W-1:0]   pulse_q, pulse_d;
    mode_t                mode_q, mode_d;
    logic                 rec_prev_q;
    logic                 samp_valid;
    logic                 abort;
    logic                 frame_start;

    // Next-state logic: start on rec_flag rising, abort on rec_flag low mid-frame
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        pulse_d     = pulse_q;
        mode_d      = mode_q;
        samp_valid  = 1'b0;
        abort       = 1'b0;
        frame_start = (bin_q == '0) && (pulse_q == '0);

        case (state_q)
            ST_IDLE: begin
                if (rec_flag && !rec_prev_q) begin
                    state_d    = ST_RUN;
                    samp_valid = 1'b1;
                end
            end
            ST_RUN: begin
                if (rec_flag) begin
                    samp_valid = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    abort   = !frame_start;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (samp_valid) begin
            bin_d = bin_q + BIN_W'(1);
            if (bin_q == '1) begin
                pulse_d = pulse_q + PULSE_W'(1);
            end
            // Mode is only sampled on the first sample of each frame
            if (frame_start) begin
                case (mode)
                    2'd1:    mode_d = MODE_TWO;
                    2'd2:    mode_d = MODE_THREE;
                    default: mode_d = MODE_BYPASS;
                endcase
            end
        end else if (state_d == ST_IDLE) begin
            bin_d   = '0;
            pulse_d = '0;
        end
    end

    // FSM and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            pulse_q    <= '0;
            mode_q     <= MODE_BYPASS;
            rec_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            pulse_q    <= pulse_d;
            mode_q     <= mode_d;
            rec_prev_q <= rec_flag;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture sample, read pulse history
    // ------------------------------------------------------------------
    logic                 s1_valid_q;
    logic [WIDTH-1:0]     s1_in_i_q, s1_in_q_q;
    logic [BIN_W-1:0]     s1_bin_q;
    logic [PULSE_W-1:0]   s1_pulse_q;
    mode_t                s1_mode_q;
    logic [2*WIDTH-1:0]   h1_rd_q, h2_rd_q;
    logic [2*WIDTH-1:0]   dly1_mem [RANGE_BINS];
    logic [2*WIDTH-1:0]   dly2_mem [RANGE_BINS];

    // Stage-1 control/data capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_in_i_q  <= '0;
            s1_in_q_q  <= '0;
            s1_bin_q   <= '0;
            s1_pulse_q <= '0;
            s1_mode_q  <= MODE_BYPASS;
        end else begin
            s1_valid_q <= samp_valid;
            if (samp_valid) begin
                s1_in_i_q  <= signal_I;
                s1_in_q_q  <= signal_Q;
                s1_bin_q   <= bin_q;
                s1_pulse_q <= pulse_q;
                s1_mode_q  <= mode_d;
            end
        end
    end

    // Delay lines: read at sample time, shift x[p]->d1 and x[p-1]->d2 one clk later.
    // The same bin is revisited only RANGE_BINS clks later, so the late write is safe.
    always_ff @(posedge clk) begin
        if (samp_valid) begin
            h1_rd_q <= dly1_mem[bin_q];
            h2_rd_q <= dly2_mem[bin_q];
        end
        if (s1_valid_q) begin
            dly1_mem[s1_bin_q] <= {s1_in_i_q, s1_in_q_q};
            dly2_mem[s1_bin_q] <= h1_rd_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: canceller
    // ------------------------------------------------------------------
    logic signed [MTI_W-1:0] x_i, x_q, h1_i, h1_q, h2_i, h2_q, y_i, y_q;
    logic                    y_ok, y_first, y_last;

    // Canceller arithmetic and pulse-validity decode
    always_comb begin
        x_i     = sext_in(s1_in_i_q);
        x_q     = sext_in(s1_in_q_q);
        h1_i    = sext_in(h1_rd_q[2*WIDTH-1 -: WIDTH]);
        h1_q    = sext_in(h1_rd_q[WIDTH-1:0]);
        h2_i    = sext_in(h2_rd_q[2*WIDTH-1 -: WIDTH]);
        h2_q    = sext_in(h2_rd_q[WIDTH-1:0]);
        y_i     = x_i;
        y_q     = x_q;
        y_ok    = 1'b1;
        y_first = (s1_pulse_q == '0);
        y_last  = (s1_pulse_q == '1);
        case (s1_mode_q)
            MODE_TWO: begin
                y_i     = x_i - h1_i;
                y_q     = x_q - h1_q;
                y_ok    = (s1_pulse_q != '0);
                y_first = (s1_pulse_q == PULSE_W'(1));
            end
            MODE_THREE: begin
                y_i     = x_i - (h1_i <<< 1) + h2_i;
                y_q     = x_q - (h1_q <<< 1) + h2_q;
                y_ok    = (s1_pulse_q >= PULSE_W'(2));
                y_first = (s1_pulse_q == PULSE_W'(2));
            end
            default: ;
        endcase
        if (!y_ok) begin
            y_i = '0;
            y_q = '0;
        end
    end

    logic                 s2_valid_q, s2_ok_q, s2_first_q, s2_last_q;
    logic [MTI_W-1:0]     s2_y_i_q, s2_y_q_q;
    logic [BIN_W-1:0]     s2_bin_q;

    // Stage-2 register; an abort drops the in-flight sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            s2_ok_q    <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_y_i_q   <= '0;
            s2_y_q_q   <= '0;
            s2_bin_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q && !abort;
            if (s1_valid_q) begin
                s2_ok_q    <= y_ok;
                s2_first_q <= y_first;
                s2_last_q  <= y_last;
                s2_y_i_q   <= y_i;
                s2_y_q_q   <= y_q;
                s2_bin_q   <= s1_bin_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: MTI outputs and accumulator read
    // ------------------------------------------------------------------
    logic                 mti_valid_q;
    logic [MTI_W-1:0]     mti_i_q, mti_q_q;
    logic                 s3_valid_q, s3_first_q, s3_last_q;
    logic [MTI_W-1:0]     s3_y_i_q, s3_y_q_q;
    logic [BIN_W-1:0]     s3_bin_q;
    logic [2*ACC_W-1:0]   acc_rd_q;
    logic [2*ACC_W-1:0]   acc_mem [RANGE_BINS];

    // MTI output register and stage-3 accumulator-side register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mti_valid_q <= 1'b0;
            mti_i_q     <= '0;
            mti_q_q     <= '0;
            s3_valid_q  <= 1'b0;
            s3_first_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            s3_y_i_q    <= '0;
            s3_y_q_q    <= '0;
            s3_bin_q    <= '0;
        end else begin
            mti_valid_q <= s2_valid_q && s2_ok_q;
            s3_valid_q  <= s2_valid_q && s2_ok_q && !abort;
            if (s2_valid_q) begin
                mti_i_q    <= s2_y_i_q;
                mti_q_q    <= s2_y_q_q;
                s3_first_q <= s2_first_q;
                s3_last_q  <= s2_last_q;
                s3_y_i_q   <= s2_y_i_q;
                s3_y_q_q   <= s2_y_q_q;
                s3_bin_q   <= s2_bin_q;
            end
        end
    end

    logic signed [ACC_W-1:0] rd_i, rd_q, sum_i, sum_q;
    logic                    acc_wr_en;

    // Running sum: first valid pulse overwrites stale RAM contents
    always_comb begin
        rd_i      = acc_rd_q[2*ACC_W-1 -: ACC_W];
        rd_q      = acc_rd_q[ACC_W-1:0];
        sum_i     = sext_mti(s3_y_i_q);
        sum_q     = sext_mti(s3_y_q_q);
        if (!s3_first_q) begin
            sum_i = rd_i + sext_mti(s3_y_i_q);
            sum_q = rd_q + sext_mti(s3_y_q_q);
        end
        acc_wr_en = s3_valid_q && !s3_last_q;
    end

    // Accumulator RAM: read for stage 3, write-back from stage 4 (not on last pulse)
    always_ff @(posedge clk) begin
        if (s2_valid_q) begin
            acc_rd_q <= acc_mem[s2_bin_q];
        end
        if (acc_wr_en) begin
            acc_mem[s3_bin_q] <= {sum_i, sum_q};
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: integrated outputs on the final pulse of the frame
    // ------------------------------------------------------------------
    logic                 acc_valid_q, start_q, done_q;
    logic [ACC_W-1:0]     acc_i_q, acc_q_q;
    logic [BIN_W-1:0]     acc_bin_q;

    // Integrated output register with start/done strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_valid_q <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            acc_bin_q   <= '0;
        end else begin
            acc_valid_q <= s3_valid_q && s3_last_q;
            start_q     <= s3_valid_q && s3_last_q && (s3_bin_q == '0);
            done_q      <= s3_valid_q && s3_last_q && (s3_bin_q == '1);
            if (s3_valid_q && s3_last_q) begin
                acc_i_q   <= sum_i;
                acc_q_q   <= sum_q;
                acc_bin_q <= s3_bin_q;
            end
        end
    end

    assign MTI_I_out = mti_i_q;
    assign MTI_Q_out = mti_q_q;
    assign mti_valid = mti_valid_q;

`ifdef MTI_ABS2_EN
    logic [2*ACC_W-1:0] ext_i, ext_q, abs2_d;
    logic [2*ACC_W-1:0] abs2_q;
    logic               o_valid_q, o_start_q, o_done_q;
    logic [ACC_W-1:0]   o_i_q, o_q_q;
    logic [BIN_W-1:0]   o_bin_q;

    // Magnitude squared; true result fits in 2*ACC_W so modulo products are exact
    always_comb begin
        ext_i  = {{ACC_W{acc_i_q[ACC_W-1]}}, acc_i_q};
        ext_q  = {{ACC_W{acc_q_q[ACC_W-1]}}, acc_q_q};
        abs2_d = ext_i * ext_i + ext_q * ext_q;
    end

    // Extra output stage keeping acc_* aligned with acc_abs2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid_q <= 1'b0;
            o_start_q <= 1'b0;
            o_done_q  <= 1'b0;
            o_i_q     <= '0;
            o_q_q     <= '0;
            o_bin_q   <= '0;
            abs2_q    <= '0;
        end else begin
            o_valid_q <= acc_valid_q;
            o_start_q <= start_q;
            o_done_q  <= done_q;
            if (acc_valid_q) begin
                o_i_q   <= acc_i_q;
                o_q_q   <= acc_q_q;
                o_bin_q <= acc_bin_q;
                abs2_q  <= abs2_d;
            end
        end
    end

    assign acc_I      = o_i_q;
    assign acc_Q      = o_q_q;
    assign acc_valid  = o_valid_q;
    assign acc_bin    = o_bin_q;
    assign start_flag = o_start_q;
    assign frame_done = o_done_q;
    assign acc_abs2   = abs2_q;
`else
    assign acc_I      = acc_i_q;
    assign acc_Q      = acc_q_q;
    assign acc_valid  = acc_valid_q;
    assign acc_bin    = acc_bin_q;
    assign start_flag = start_q;
    assign frame_done = done_q;
`endif

endmodule

// File: tb/tb_mti_pulse_integrator.sv
// Directed testbench for mti_pulse_integrator (default build, 3-clk acc latency).

module tb_mti_pulse_integrator;

    localparam int WIDTH = 12;
    localparam int RB    = 512;
    localparam int NP    = 16;
    localparam int MTI_W = WIDTH + 2;
    localparam int ACC_W = MTI_W + 4;
    localparam int BIN_W = 9;
    localparam int FRAME = RB * NP;
    localparam int SENT  = 99999;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    rec_flag;
    logic [1:0]              mode;
    logic signed [WIDTH-1:0] signal_I, signal_Q;
    logic signed [MTI_W-1:0] MTI_I_out, MTI_Q_out;
    logic                    mti_valid;
    logic signed [ACC_W-1:0] acc_I, acc_Q;
    logic                    acc_valid;
    logic [BIN_W-1:0]        acc_bin;
    logic                    start_flag, frame_done;

    int checks = 0;
    int errors = 0;

    // observation statistics filled by drive_frame
    int mti_cnt, mti_first_t, mti_i_min, mti_i_max, mti_q_min, mti_q_max;
    int mti_b5 [NP];
    int acc_cnt, acc_first_t, acc_i_min, acc_i_max, acc_q_min, acc_q_max, last_bin, seq_breaks;
    int start_cnt, start_bad, done_cnt, done_bad, done_t0, done_t1;

    always #5 clk = ~clk;

    mti_pulse_integrator #(
        .WIDTH(WIDTH),
        .RANGE_BINS(RB),
        .NUM_PULSES(NP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rec_flag(rec_flag),
        .mode(mode),
        .signal_I(signal_I),
        .signal_Q(signal_Q),
        .MTI_I_out(MTI_I_out),
        .MTI_Q_out(MTI_Q_out),
        .mti_valid(mti_valid),
        .acc_I(acc_I),
        .acc_Q(acc_Q),
        .acc_valid(acc_valid),
        .acc_bin(acc_bin),
        .start_flag(start_flag),
        .frame_done(frame_done)
    );

    // Drives n_samp samples with rec_flag high (mode shown correctly only on each
    // frame's first sample, garbage otherwise), then `tail` idle clocks. Sample t is
    // taken at step t; outputs are observed 1 ns after that edge.
    task automatic drive_frame(input logic [1:0] m, input int n_samp, input int i_even,
                               input int i_odd, input int q_val, input int tail);
        int p, s, v;
        mti_cnt = 0; mti_first_t = -1; acc_cnt = 0; acc_first_t = -1;
        mti_i_min = 1 << 30; mti_i_max = -(1 << 30); mti_q_min = 1 << 30; mti_q_max = -(1 << 30);
        acc_i_min = 1 << 30; acc_i_max = -(1 << 30); acc_q_min = 1 << 30; acc_q_max = -(1 << 30);
        last_bin = -1; seq_breaks = 0; start_cnt = 0; start_bad = 0;
        done_cnt = 0; done_bad = 0; done_t0 = -1; done_t1 = -1;
        for (int k = 0; k < NP; k++) mti_b5[k] = SENT;
        for (int t = 0; t < n_samp + tail; t++) begin
            if (t < n_samp) begin
                p        = (t / RB) % NP;
                rec_flag = 1'b1;
                mode     = (t % FRAME == 0) ? m : (m ^ 2'b01);
                signal_I = 12'((p % 2 == 0) ? i_even : i_odd);
                signal_Q = 12'(q_val);
            end else begin
                rec_flag = 1'b0;
                mode     = m ^ 2'b01;
                signal_I = '0;
                signal_Q = '0;
            end
            @(posedge clk);
            #1;
            if (mti_valid) begin
                if (mti_cnt == 0) mti_first_t = t;
                mti_cnt++;
                v = int'(MTI_I_out);
                if (v < mti_i_min) mti_i_min = v;
                if (v > mti_i_max) mti_i_max = v;
                if (int'(MTI_Q_out) < mti_q_min) mti_q_min = int'(MTI_Q_out);
                if (int'(MTI_Q_out) > mti_q_max) mti_q_max = int'(MTI_Q_out);
                s = t - 2;
                if (s >= 0 && s % RB == 5) mti_b5[(s / RB) % NP] = v;
            end
            if (acc_valid) begin
                if (acc_cnt == 0) acc_first_t = t;
                else if (int'(acc_bin) != (last_bin + 1) % RB) seq_breaks++;
                acc_cnt++;
                last_bin = int'(acc_bin);
                if (int'(acc_I) < acc_i_min) acc_i_min = int'(acc_I);
                if (int'(acc_I) > acc_i_max) acc_i_max = int'(acc_I);
                if (int'(acc_Q) < acc_q_min) acc_q_min = int'(acc_Q);
                if (int'(acc_Q) > acc_q_max) acc_q_max = int'(acc_Q);
            end
            if (start_flag) begin
                start_cnt++;
                if (!acc_valid || int'(acc_bin) != 0) start_bad++;
            end
            if (frame_done) begin
                if (done_cnt == 0) done_t0 = t;
                else if (done_cnt == 1) done_t1 = t;
                done_cnt++;
                if (!acc_valid || int'(acc_bin) != RB - 1) done_bad++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rec_flag = 1'b0; mode = 2'd0; signal_I = '0; signal_Q = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mti_valid !== 1'b0 || acc_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valids actual mti=%b acc=%b expected 0 0", mti_valid, acc_valid); end
        checks++; if (MTI_I_out !== '0 || MTI_Q_out !== '0) begin errors++;
            $display("FAIL reset_mti actual %0d %0d expected 0 0", MTI_I_out, MTI_Q_out); end
        checks++; if (acc_I !== '0 || acc_Q !== '0 || acc_bin !== '0) begin errors++;
            $display("FAIL reset_acc actual %0d %0d bin %0d expected 0", acc_I, acc_Q, acc_bin); end
        checks++; if (start_flag !== 1'b0 || frame_done !== 1'b0) begin errors++;
            $display("FAIL reset_strobes actual %b %b expected 0 0", start_flag, frame_done); end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_bypass();
        drive_frame(2'd0, FRAME, 100, 100, -50, 8);
        checks++; if (acc_cnt !== RB) begin errors++;
            $display("FAIL bypass_acc_count actual=%0d expected=%0d", acc_cnt, RB); end
        checks++; if (acc_i_min !== 1600 || acc_i_max !== 1600) begin errors++;
            $display("FAIL bypass_acc_I actual min=%0d max=%0d expected 1600", acc_i_min, acc_i_max); end
        checks++; if (acc_q_min !== -800 || acc_q_max !== -800) begin errors++;
            $display("FAIL bypass_acc_Q actual min=%0d max=%0d expected -800", acc_q_min, acc_q_max); end
        checks++; if (acc_first_t !== FRAME - RB + 3) begin errors++;
            $display("FAIL bypass_acc_latency actual=%0d expected=%0d", acc_first_t, FRAME - RB + 3); end
        checks++; if (mti_first_t !== 2 || mti_cnt !== FRAME) begin errors++;
            $display("FAIL bypass_mti_timing actual first=%0d cnt=%0d expected 2 %0d", mti_first_t, mti_cnt, FRAME); end
        checks++; if (mti_i_min !== 100 || mti_i_max !== 100 || mti_q_min !== -50 || mti_q_max !== -50) begin errors++;
            $display("FAIL bypass_mti_value actual I=%0d..%0d Q=%0d..%0d expected 100 -50", mti_i_min, mti_i_max, mti_q_min, mti_q_max); end
        checks++; if (seq_breaks !== 0) begin errors++;
            $display("FAIL bypass_bin_sequence actual breaks=%0d expected 0", seq_breaks); end
        checks++; if (start_cnt !== 1 || start_bad !== 0 || done_cnt !== 1 || done_bad !== 0) begin errors++;
            $display("FAIL bypass_strobes actual start=%0d/%0d done=%0d/%0d expected 1/0 1/0", start_cnt, start_bad, done_cnt, done_bad); end
    endtask

    task automatic test_two_pulse_const();
        drive_frame(2'd1, FRAME, 100, 100, -50, 8);
        checks++; if (mti_b5[0] !== SENT || mti_first_t !== RB + 2) begin errors++;
            $display("FAIL two_const_first_valid actual p0=%0d first=%0d expected none %0d", mti_b5[0], mti_first_t, RB + 2); end
        checks++; if (mti_cnt !== FRAME - RB) begin errors++;
            $display("FAIL two_const_mti_count actual=%0d expected=%0d", mti_cnt, FRAME - RB); end
        checks++; if (mti_i_min !== 0 || mti_i_max !== 0 || mti_q_min !== 0 || mti_q_max !== 0) begin errors++;
            $display("FAIL two_const_mti_zero actual I=%0d..%0d Q=%0d..%0d expected 0", mti_i_min, mti_i_max, mti_q_min, mti_q_max); end
        checks++; if (acc_cnt !== RB || acc_i_min !== 0 || acc_i_max !== 0 || acc_q_max !== 0) begin errors++;
            $display("FAIL two_const_acc actual cnt=%0d I=%0d..%0d Q=%0d expected %0d 0", acc_cnt, acc_i_min, acc_i_max, acc_q_max, RB); end
    endtask

    task automatic test_two_pulse_alt();
        drive_frame(2'd1, FRAME, 100, -100, 0, 8);
        checks++; if (mti_b5[1] !== -200 || mti_b5[2] !== 200 || mti_b5[15] !== -200) begin errors++;
            $display("FAIL two_alt_mti actual p1=%0d p2=%0d p15=%0d expected -200 200 -200", mti_b5[1], mti_b5[2], mti_b5[15]); end
        checks++; if (acc_cnt !== RB || acc_i_min !== -200 || acc_i_max !== -200) begin errors++;
            $display("FAIL two_alt_acc actual cnt=%0d I=%0d..%0d expected %0d -200", acc_cnt, acc_i_min, acc_i_max, RB); end
    endtask

    task automatic test_three_pulse_alt();
        drive_frame(2'd2, FRAME, 100, -100, 0, 8);
        checks++; if (mti_b5[1] !== SENT || mti_first_t !== 2 * RB + 2 || mti_cnt !== FRAME - 2 * RB) begin errors++;
            $display("FAIL three_alt_valid actual p1=%0d first=%0d cnt=%0d expected none %0d %0d", mti_b5[1], mti_first_t, mti_cnt, 2 * RB + 2, FRAME - 2 * RB); end
        checks++; if (mti_b5[2] !== 400 || mti_b5[3] !== -400 || mti_b5[15] !== -400) begin errors++;
            $display("FAIL three_alt_mti actual p2=%0d p3=%0d p15=%0d expected 400 -400 -400", mti_b5[2], mti_b5[3], mti_b5[15]); end
        checks++; if (acc_cnt !== RB || acc_i_min !== 0 || acc_i_max !== 0) begin errors++;
            $display("FAIL three_alt_acc actual cnt=%0d I=%0d..%0d expected %0d 0", acc_cnt, acc_i_min, acc_i_max, RB); end
    endtask

    task automatic test_abort();
        drive_frame(2'd0, 7 * RB + 100, 100, 100, -50, 20);
        checks++; if (acc_cnt !== 0 || done_cnt !== 0 || start_cnt !== 0) begin errors++;
            $display("FAIL abort_no_output actual acc=%0d done=%0d start=%0d expected 0 0 0", acc_cnt, done_cnt, start_cnt); end
        drive_frame(2'd0, FRAME, 100, 100, -50, 8);
        checks++; if (acc_cnt !== RB || acc_i_min !== 1600 || acc_i_max !== 1600 || acc_q_min !== -800 || acc_q_max !== -800) begin errors++;
            $display("FAIL abort_clean_frame actual cnt=%0d I=%0d..%0d Q=%0d..%0d expected %0d 1600 -800", acc_cnt, acc_i_min, acc_i_max, acc_q_min, acc_q_max, RB); end
        checks++; if (done_cnt !== 1 || done_bad !== 0) begin errors++;
            $display("FAIL abort_clean_done actual=%0d bad=%0d expected 1 0", done_cnt, done_bad); end
    endtask

    task automatic test_reset_midframe();
        drive_frame(2'd0, 10 * RB + 37, 100, 100, -50, 0);
        rst = 1'b0;
        #1;
        checks++; if (MTI_I_out !== '0 || mti_valid !== 1'b0) begin errors++;
            $display("FAIL midreset_mti actual %0d v=%b expected 0 0", MTI_I_out, mti_valid); end
        checks++; if (acc_I !== '0 || acc_Q !== '0 || acc_bin !== '0 || acc_valid !== 1'b0) begin errors++;
            $display("FAIL midreset_acc actual %0d %0d bin %0d v=%b expected 0", acc_I, acc_Q, acc_bin, acc_valid); end
        rec_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mti_valid !== 1'b0 || acc_valid !== 1'b0 || acc_I !== '0) begin errors++;
            $display("FAIL postreset_idle actual mv=%b av=%b acc=%0d expected 0 0 0", mti_valid, acc_valid, acc_I); end
    endtask

    task automatic test_back_to_back();
        drive_frame(2'd0, 2 * FRAME, 100, 100, -50, 8);
        checks++; if (done_cnt !== 2 || done_bad !== 0) begin errors++;
            $display("FAIL b2b_done_count actual=%0d bad=%0d expected 2 0", done_cnt, done_bad); end
        checks++; if (done_t1 - done_t0 !== FRAME) begin errors++;
            $display("FAIL b2b_done_spacing actual=%0d expected=%0d", done_t1 - done_t0, FRAME); end
        checks++; if (start_cnt !== 2 || start_bad !== 0) begin errors++;
            $display("FAIL b2b_start actual=%0d bad=%0d expected 2 0", start_cnt, start_bad); end
        checks++; if (acc_cnt !== 2 * RB || acc_i_min !== 1600 || acc_i_max !== 1600 || seq_breaks !== 0) begin errors++;
            $display("FAIL b2b_acc actual cnt=%0d I=%0d..%0d breaks=%0d expected %0d 1600 0", acc_cnt, acc_i_min, acc_i_max, seq_breaks, 2 * RB); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_two_pulse_const();
        test_two_pulse_alt();
        test_three_pulse_alt();
        test_abort();
        test_reset_midframe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
